fft_frame_pingpong_buffer: RTL and testbench
============================================

Name: fft_frame_pingpong_buffer

Overview:
- Store-and-forward frame buffer for the FFT output path: takes serialized FFT result words from the FFT output crossbar and releases a frame to the interconnect arbiter sink only after the whole frame is stored.
- Two banks (ping-pong), so one frame can fill while the previous frame drains.
- The arbiter then never sees a partial frame interleaved with other sources.
- Unbuffered sources (loopback, SPI master readback) are unaffected.

Parameters:
- BIT_WIDTH, 32, data word width.
- N_SAMPLES, 8, words per frame. Power of two, >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low. Asserted when 0; clears all state immediately, independent of clk.
- recv_msg  input  BIT_WIDTH  incoming sample word.
- recv_val  input  1  recv_msg is valid.
- recv_rdy  output  1  buffer can accept a word this cycle.
- send_msg  output  BIT_WIDTH  outgoing sample word.
- send_val  output  1  send_msg is valid.
- send_rdy  input  1  downstream accepts send_msg.
- flush  input  1  discard the partially filled frame.
- full_banks  output  2  number of complete frames held (0..2).
- frame_cnt  output  8  count of fully drained frames; wraps 255 -> 0.

Behaviour:
- State:
  - mem[2][N_SAMPLES] of BIT_WIDTH.
  - wr_bank, rd_bank (1 bit each).
  - wr_idx, rd_idx ($clog2(N_SAMPLES) bits each).
  - full[1:0].
  - frame_cnt.
- Reset (reset=0): wr_bank=rd_bank=0, wr_idx=rd_idx=0, full=00, frame_cnt=0. Resulting outputs: recv_rdy=1, send_val=0, send_msg=0, full_banks=0. Mem contents are not cleared.
- Accept (recv fire) = recv_val & recv_rdy. Send (send fire) = send_val & send_rdy.
- Combinational outputs:
  - recv_rdy = !full[wr_bank] & !flush.
  - send_val = full[rd_bank].
  - send_msg = full[rd_bank] ? mem[rd_bank][rd_idx] : 0.
  - full_banks = full[0] + full[1].
- Fill side, per bank FSM EMPTY -> FILLING -> FULL -> (draining) -> EMPTY:
  - On recv fire: mem[wr_bank][wr_idx] <= recv_msg; wr_idx++.
  - If wr_idx == N_SAMPLES-1 on that fire: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0.
- Drain side:
  - On send fire: rd_idx++.
  - If rd_idx == N_SAMPLES-1 on that fire: full[rd_bank] <= 0, rd_bank toggles, rd_idx <= 0, frame_cnt++ (mod 256).
- Latency: first word of a frame is presented (send_val=1) the cycle after the last word of that frame is accepted, provided rd_bank points to it.
- Throughput: with send_rdy held high, sustained 1 word/cycle in and out; fill of frame k+1 overlaps drain of frame k.
- Simultaneous fill-complete and drain-complete in one cycle: they always hit different banks; both updates apply. full_banks stays the same net (one set, one cleared).
- Both banks full: recv_rdy=0 until the drain of rd_bank completes. recv_rdy rises the cycle after the final send fire of that bank.
- Empty: send_val=0, send_msg=0. send_rdy is ignored.
- flush=1:
  - Forces recv_rdy=0, so no write that cycle.
  - wr_idx <= 0; words of the partial frame are discarded.
  - full[] and the drain side are untouched; a flush while draining does not disturb the drain.
  - No effect if wr_idx==0.
- Mid-operation reset: all in-flight frames are discarded; outputs go to reset values asynchronously.
- send_msg and full_banks change only on clk edges or reset.
- No combinational path from send_rdy to recv_rdy.

Test Plan:
- Reset values: hold reset=0 for 3 cycles with recv_val=1 and send_rdy=1, then release -> recv_rdy=1, send_val=0, send_msg=0, full_banks=0, frame_cnt=0, and nothing is written during reset.
- Single frame: feed 1..8 on consecutive cycles with send_rdy=1 -> send_val rises the cycle after word 8 is accepted, outputs 1..8 in order on 8 consecutive cycles, then frame_cnt=1 and full_banks=0.
- Back-pressure: send_rdy=0, offer words 0x10..0x20 continuously -> 16 words accepted, full_banks=2, recv_rdy=0 at word 17. Raise send_rdy -> 0x10..0x17 drain, recv_rdy returns the cycle after 0x17 is sent, 0x20 is accepted next.
- Streaming overlap: 3 back-to-back frames with send_rdy=1 -> no bubble on recv_rdy, output is 24 words in order, frame_cnt=3.
- Flush: accept 0xA,0xB,0xC, pulse flush, then feed 1..8 -> output is exactly 1..8; 0xA–0xC never appear.
- Reset mid-drain: after 3 words of a full frame are sent, assert reset -> send_val=0 and full_banks=0 immediately. After release, a new frame 1..8 drains correctly and frame_cnt restarts at 0.
- Wrap: drain 256 frames -> frame_cnt reads 0.

Source files
------------

// File: rtl/fft_frame_pingpong_buffer_if.sv
// Valid/ready word stream between the FFT crossbar, the frame buffer and the arbiter.
// Signals: msg (data word), val (word valid), rdy (sink accepts); master drives msg/val.
interface fft_frame_pingpong_buffer_if #(
    parameter int BIT_WIDTH = 32
);
    logic [BIT_WIDTH-1:0] msg;
    logic                 val;
    logic                 rdy;

    modport master (output msg, output val, input rdy);
    modport slave  (input msg, input val, output rdy);
endinterface

// File: rtl/fft_frame_pingpong_buffer.sv
// Ping-pong store-and-forward buffer: releases a frame only once it is fully stored.
// Ports: clk, reset (async active-low), recv (slave stream), send (master stream), flush, full_banks, frame_cnt.
module fft_frame_pingpong_buffer #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    fft_frame_pingpong_buffer_if.slave    recv,
    fft_frame_pingpong_buffer_if.master   send,
    input  logic                          flush,
    output logic [1:0]                    full_banks,
    output logic [7:0]                    frame_cnt
);
    localparam int IW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_SAMPLES - 1);

    logic [BIT_WIDTH-1:0] mem [2][N_SAMPLES];

    logic          wr_bank, wr_bank_n;
    logic          rd_bank, rd_bank_n;
    logic [IW-1:0] wr_idx, wr_idx_n;
    logic [IW-1:0] rd_idx, rd_idx_n;
    logic [1:0]    full, full_n;
    logic [7:0]    fcnt, fcnt_n;

    logic recv_fire;
    logic send_fire;

    assign recv.rdy   = !full[wr_bank] && !flush;
    assign send.val   = full[rd_bank];
    assign send.msg   = full[rd_bank] ? mem[rd_bank][rd_idx] : '0;
    assign full_banks = {1'b0, full[0]} + {1'b0, full[1]};
    assign frame_cnt  = fcnt;

    assign recv_fire = recv.val && recv.rdy;
    assign send_fire = send.val && send.rdy;

    // Fill and drain completions in the same cycle always target
    // different banks, so both full_n updates can coexist.
    always_comb begin
        wr_bank_n = wr_bank;
        rd_bank_n = rd_bank;
        wr_idx_n  = wr_idx;
        rd_idx_n  = rd_idx;
        full_n    = full;
        fcnt_n    = fcnt;

        if (flush) begin
            wr_idx_n = '0;
        end else if (recv_fire) begin
            if (wr_idx == LAST) begin
                full_n[wr_bank] = 1'b1;
                wr_bank_n       = !wr_bank;
                wr_idx_n        = '0;
            end else begin
                wr_idx_n = wr_idx + IW'(1);
            end
        end

        if (send_fire) begin
            if (rd_idx == LAST) begin
                full_n[rd_bank] = 1'b0;
                rd_bank_n       = !rd_bank;
                rd_idx_n        = '0;
                fcnt_n          = fcnt + 8'd1;
            end else begin
                rd_idx_n = rd_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            full    <= 2'b00;
            fcnt    <= 8'd0;
        end else begin
            wr_bank <= wr_bank_n;
            rd_bank <= rd_bank_n;
            wr_idx  <= wr_idx_n;
            rd_idx  <= rd_idx_n;
            full    <= full_n;
            fcnt    <= fcnt_n;
        end
    end

    // Storage is not reset; stale words are masked by full[].
    always_ff @(posedge clk) begin
        if (recv_fire) begin
            mem[wr_bank][wr_idx] <= recv.msg;
        end
    end
endmodule

// File: tb/tb_fft_frame_pingpong_buffer.sv
// Randomized and directed bench for the ping-pong frame buffer against a queue model.
// Drives inputs on the falling edge and compares outputs before the next rising edge.
module tb_fft_frame_pingpong_buffer;
    localparam int BW = 32;
    localparam int N  = 8;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] full_banks;
    logic [7:0] frame_cnt;

    fft_frame_pingpong_buffer_if #(.BIT_WIDTH(BW)) rx_if ();
    fft_frame_pingpong_buffer_if #(.BIT_WIDTH(BW)) tx_if ();

    fft_frame_pingpong_buffer #(
        .BIT_WIDTH(BW),
        .N_SAMPLES(N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .recv      (rx_if.slave),
        .send      (tx_if.master),
        .flush     (flush),
        .full_banks(full_banks),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: words of complete, not yet sent frames in order, plus the frame being filled.
    logic [BW-1:0] m_out[$];
    logic [BW-1:0] m_part[$];
    int            m_sent;
    logic [7:0]    m_fc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_nfull();
        return (m_out.size() + N - 1) / N;
    endfunction

    task automatic m_clear();
        m_out.delete();
        m_part.delete();
        m_sent = 0;
        m_fc   = 8'd0;
    endtask

    // One clock cycle: drive, compare, then advance the model on the edge.
    task automatic cyc(input logic v, input logic [BW-1:0] m, input logic sr,
                       input logic fl, output bit acc);
        bit sfire;
        rx_if.val = v;
        rx_if.msg = m;
        tx_if.rdy = sr;
        flush     = fl;
        #1;
        check("recv_rdy", 32'(rx_if.rdy), 32'(m_nfull() < 2 && !fl));
        check("send_val", 32'(tx_if.val), 32'(m_nfull() > 0));
        check("send_msg", tx_if.msg, (m_nfull() > 0) ? m_out[0] : '0);
        check("full_banks", 32'(full_banks), 32'(m_nfull()));
        check("frame_cnt", 32'(frame_cnt), 32'(m_fc));
        acc   = v && (m_nfull() < 2) && !fl;
        sfire = sr && (m_nfull() > 0);
        @(posedge clk);
        if (sfire) begin
            void'(m_out.pop_front());
            m_sent++;
            if (m_sent % N == 0) m_fc++;
        end
        if (fl) begin
            m_part.delete();
        end else if (acc) begin
            m_part.push_back(m);
            if (m_part.size() == N) begin
                foreach (m_part[i]) m_out.push_back(m_part[i]);
                m_part.delete();
            end
        end
        @(negedge clk);
    endtask

    task automatic feed(input logic [BW-1:0] base, input int n, input logic sr);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int tries;
            acc   = 0;
            tries = 0;
            while (!acc && tries < 64) begin
                cyc(1'b1, base + BW'(i), sr, 1'b0, acc);
                tries++;
            end
            if (!acc) check("feed_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic idle(input int n, input logic sr);
        bit acc;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, sr, 1'b0, acc);
    endtask

    // Async reset held for three cycles while traffic is offered.
    task automatic do_reset();
        reset     = 1'b0;
        rx_if.val = 1'b1;
        rx_if.msg = 32'h55;
        tx_if.rdy = 1'b1;
        flush     = 1'b0;
        #1;
        check("rst_recv_rdy", 32'(rx_if.rdy), 32'd1);
        check("rst_send_val", 32'(tx_if.val), 32'd0);
        check("rst_send_msg", tx_if.msg, 32'd0);
        check("rst_full_banks", 32'(full_banks), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (3) @(negedge clk);
        m_clear();
        reset = 1'b1;
    endtask

    initial begin
        bit acc;
        int tries;
        rx_if.val = 1'b0;
        rx_if.msg = '0;
        tx_if.rdy = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        m_clear();
        @(negedge clk);
        do_reset();
        idle(2, 1'b1);

        // Single frame
        feed(32'd1, N, 1'b1);
        idle(N + 2, 1'b1);
        check("single_fc", 32'(frame_cnt), 32'd1);

        // Back-pressure: two frames stored, third blocked
        feed(32'h10, 2 * N, 1'b0);
        cyc(1'b1, 32'h20, 1'b0, 1'b0, acc);
        check("bp_blocked", 32'(acc), 32'd0);
        check("bp_full2", 32'(full_banks), 32'd2);
        tries = 0;
        acc   = 0;
        while (!acc && tries < 32) begin
            cyc(1'b1, 32'h20, 1'b1, 1'b0, acc);
            tries++;
        end
        check("bp_resume_cycle", 32'(tries), 32'(N + 1));
        idle(2 * N + 2, 1'b1);

        // Streaming overlap
        do_reset();
        feed(32'h100, 3 * N, 1'b1);
        idle(N + 2, 1'b1);
        check("stream_fc", 32'(frame_cnt), 32'd3);

        // Flush discards partial frame
        feed(32'hA, 3, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1, acc);
        feed(32'd1, N, 1'b1);
        idle(N + 2, 1'b1);
        check("flush_fc", 32'(frame_cnt), 32'd4);

        // Reset in the middle of a drain
        feed(32'h200, N, 1'b0);
        idle(3, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_send_val", 32'(tx_if.val), 32'd0);
        check("midrst_full_banks", 32'(full_banks), 32'd0);
        check("midrst_recv_rdy", 32'(rx_if.rdy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        m_clear();
        reset = 1'b1;
        idle(1, 1'b1);
        feed(32'd1, N, 1'b1);
        idle(N + 2, 1'b1);
        check("midrst_fc", 32'(frame_cnt), 32'd1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom(),
                1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 31) == 0), acc);
        end
        idle(3 * N, 1'b1);

        // Frame counter wrap
        do_reset();
        feed(32'h1000, 256 * N, 1'b1);
        idle(N + 2, 1'b1);
        check("wrap_fc", 32'(frame_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
